// File: rtl/emu_ckpt_ctrl.sv
// emu_ckpt_ctrl: sequences one checkpoint dump/load of the FF and RAM scan chains
// against an external buffer, pausing the DUT clock for the duration.
module emu_ckpt_ctrl #(
    parameter int DATA_WIDTH = 64,
    parameter int FF_WORDS   = 4,
    parameter int MEM_WORDS  = 16,
    localparam int ADDR_WIDTH = $clog2(FF_WORDS + MEM_WORDS)
) (
    input  logic                  clk_i,
    input  logic                  resetn_i,
    input  logic                  start_i,
    input  logic                  dir_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  pause_o,
    output logic                  ff_se_o,
    output logic [DATA_WIDTH-1:0] ff_di_o,
    input  logic [DATA_WIDTH-1:0] ff_do_i,
    output logic                  ram_se_o,
    output logic                  ram_sd_o,
    output logic [DATA_WIDTH-1:0] ram_di_o,
    input  logic [DATA_WIDTH-1:0] ram_do_i,
    output logic                  buf_wen_o,
    output logic [ADDR_WIDTH-1:0] buf_waddr_o,
    output logic [DATA_WIDTH-1:0] buf_wdata_o,
    output logic [ADDR_WIDTH-1:0] buf_raddr_o,
    input  logic [DATA_WIDTH-1:0] buf_rdata_i
);
    typedef enum logic [2:0] {
        IDLE, SETTLE, FF_SHIFT, RAM_PRE, RAM_SHIFT, RAM_TAIL, RELEASE, DONE
    } state_e;

    localparam logic [ADDR_WIDTH-1:0] ONE     = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] FF_LAST = ADDR_WIDTH'(FF_WORDS - 1);
    localparam logic [ADDR_WIDTH-1:0] RM_LAST = ADDR_WIDTH'(MEM_WORDS - 1);

    state_e                state_q;
    logic [ADDR_WIDTH-1:0] cnt_q, waddr_q, raddr_q;
    logic                  dir_q, busy_q, done_q, pause_q, ff_se_q, ram_se_q, ram_sd_q, wen_q;

    // Dump recirculates the FF chain so it is left intact.
    assign ff_di_o     = dir_q ? buf_rdata_i : ff_do_i;
    assign ram_di_o    = buf_rdata_i;
    assign buf_wdata_o = ram_se_q ? ram_do_i : ff_do_i;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign pause_o     = pause_q;
    assign ff_se_o     = ff_se_q;
    assign ram_se_o    = ram_se_q;
    assign ram_sd_o    = ram_sd_q;
    assign buf_wen_o   = wen_q;
    assign buf_waddr_o = waddr_q;
    assign buf_raddr_o = raddr_q;

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            waddr_q  <= '0;
            raddr_q  <= '0;
            dir_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pause_q  <= 1'b0;
            ff_se_q  <= 1'b0;
            ram_se_q <= 1'b0;
            ram_sd_q <= 1'b0;
            wen_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                // DONE also accepts start so held-start operations run back to back.
                IDLE, DONE: begin
                    state_q <= IDLE;
                    if (start_i) begin
                        state_q <= SETTLE;
                        dir_q   <= dir_i;
                        busy_q  <= 1'b1;
                        pause_q <= 1'b1;
                        cnt_q   <= '0;
                        waddr_q <= '0;
                        raddr_q <= '0;
                    end
                end
                SETTLE: begin
                    state_q <= FF_SHIFT;
                    ff_se_q <= 1'b1;
                    wen_q   <= !dir_q;
                    if (dir_q) raddr_q <= raddr_q + ONE;
                end
                FF_SHIFT: begin
                    if (dir_q) raddr_q <= raddr_q + ONE;
                    else waddr_q <= waddr_q + ONE;
                    cnt_q <= cnt_q + ONE;
                    if (cnt_q == FF_LAST) begin
                        state_q  <= dir_q ? RAM_SHIFT : RAM_PRE;
                        cnt_q    <= '0;
                        ff_se_q  <= 1'b0;
                        wen_q    <= 1'b0;
                        ram_se_q <= 1'b1;
                        ram_sd_q <= dir_q;
                    end
                end
                RAM_PRE: begin
                    cnt_q <= cnt_q + ONE;
                    if (cnt_q == ONE) begin
                        state_q <= RAM_SHIFT;
                        cnt_q   <= '0;
                        wen_q   <= 1'b1;
                    end
                end
                RAM_SHIFT: begin
                    if (dir_q) raddr_q <= raddr_q + ONE;
                    else waddr_q <= waddr_q + ONE;
                    cnt_q <= cnt_q + ONE;
                    if (cnt_q == RM_LAST) begin
                        state_q <= dir_q ? RAM_TAIL : RELEASE;
                        cnt_q   <= '0;
                        wen_q   <= 1'b0;
                        if (!dir_q) begin
                            ram_se_q <= 1'b0;
                            ram_sd_q <= 1'b0;
                        end
                    end
                end
                RAM_TAIL: begin
                    state_q  <= RELEASE;
                    ram_se_q <= 1'b0;
                    ram_sd_q <= 1'b0;
                end
                RELEASE: begin
                    state_q <= DONE;
                    pause_q <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_emu_ckpt_ctrl.sv
// tb_emu_ckpt_ctrl: directed bench with a word-per-cycle FF/RAM chain model and
// a 1-cycle-latency buffer model, all advanced on the falling edge.
module tb_emu_ckpt_ctrl;
    localparam int DW = 64;
    localparam int AW = 3;

    logic          clk = 1'b0, resetn = 1'b0, start = 1'b0, dir = 1'b0;
    logic          busy, done, pause, ff_se, ram_se, ram_sd, buf_wen;
    logic [DW-1:0] ff_di, ff_do, ram_di, ram_do, buf_wdata, buf_rdata;
    logic [AW-1:0] buf_waddr, buf_raddr;

    emu_ckpt_ctrl #(.DATA_WIDTH(DW), .FF_WORDS(3), .MEM_WORDS(5)) dut (
        .clk_i(clk), .resetn_i(resetn), .start_i(start), .dir_i(dir),
        .busy_o(busy), .done_o(done), .pause_o(pause),
        .ff_se_o(ff_se), .ff_di_o(ff_di), .ff_do_i(ff_do),
        .ram_se_o(ram_se), .ram_sd_o(ram_sd), .ram_di_o(ram_di), .ram_do_i(ram_do),
        .buf_wen_o(buf_wen), .buf_waddr_o(buf_waddr), .buf_wdata_o(buf_wdata),
        .buf_raddr_o(buf_raddr), .buf_rdata_i(buf_rdata)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] ffc[3], mem[5], bm[8], pd, ffdi[4], ramdi[8];
    logic [DW-1:0] a_w[3], b_w[5];
    int   rcnt, wi, errors, checks;
    bit   pv;
    logic s_busy, s_done, s_pause, s_ff_se, s_ram_se, s_ram_sd;
    int   npause, nbusy, nff, nram, nsd, nboth, done_at;
    logic first_settle;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] outs();
        return DW'({busy, done, pause, ff_se, ram_se, ram_sd, buf_wen, buf_waddr, buf_raddr});
    endfunction

    task automatic drive_model();
        ff_do     = ffc[0];
        ram_do    = (rcnt >= 2 && rcnt < 7) ? mem[rcnt-2] : '0;
    endtask

    // One clock: sample the DUT mid-cycle, then apply that cycle's effects to the models.
    task automatic step();
        logic [DW-1:0] d_ff, d_ram, wd, rd;
        @(negedge clk);
        {s_busy, s_done, s_pause, s_ff_se, s_ram_se, s_ram_sd} = {busy, done, pause, ff_se, ram_se, ram_sd};
        d_ff = ff_di; d_ram = ram_di; wd = buf_wdata;
        rd = bm[buf_raddr];
        if (buf_wen) bm[buf_waddr] = wd;
        buf_rdata = rd;
        if (ff_se) begin
            ffc[0] = ffc[1]; ffc[1] = ffc[2]; ffc[2] = d_ff;
        end
        if (ram_se && !ram_sd) rcnt++;
        if (ram_se && ram_sd) begin
            if (pv && wi < 5) begin mem[wi] = pd; wi++; end
            pd = d_ram; pv = 1;
        end
        if (!ram_se) begin rcnt = 0; wi = 0; pv = 0; end
        drive_model();
    endtask

    task automatic watch(input bit clr, input int poke);
        npause = 0; nbusy = 0; nff = 0; nram = 0; nsd = 0; nboth = 0; done_at = 0; first_settle = 0;
        for (int i = 1; i <= 30 && done_at == 0; i++) begin
            step();
            if (i == 1) first_settle = s_busy && s_pause && !s_ff_se && !s_ram_se;
            if (clr && i == 1) start = 1'b0;
            if (i == poke) start = 1'b1;
            else if (poke > 0 && i == poke + 1) start = 1'b0;
            npause += int'(s_pause);
            nbusy  += int'(s_busy);
            nboth  += int'(s_ff_se && s_ram_se);
            nsd    += int'(s_ram_se && s_ram_sd);
            if (s_ff_se && nff < 4) ffdi[nff] = ff_di_last;
            if (s_ram_se && nram < 8) ramdi[nram] = ram_di_last;
            nff  += int'(s_ff_se);
            nram += int'(s_ram_se);
            if (s_done) done_at = i;
        end
    endtask

    // Data inputs to the chains as seen at the last sample point.
    logic [DW-1:0] ff_di_last, ram_di_last;
    always @(negedge clk) begin
        ff_di_last  <= ff_di;
        ram_di_last <= ram_di;
    end

    task automatic run_op(input logic d, input int poke);
        start = 1'b1; dir = d;
        watch(1'b1, poke);
    endtask

    initial begin
        errors = 0; checks = 0; rcnt = 0; wi = 0; pv = 0; pd = '0;
        for (int i = 0; i < 3; i++) begin a_w[i] = 64'hA0A0_0000_0000_00A0 + DW'(i); ffc[i] = '0; end
        for (int i = 0; i < 5; i++) begin b_w[i] = 64'hB0B0_0000_0000_00B0 + DW'(i); mem[i] = '0; end
        for (int i = 0; i < 8; i++) bm[i] = '0;
        buf_rdata = '0;
        drive_model();
        // Reset, then idle
        step(); step();
        chk("reset_outs", outs(), '0);
        resetn = 1'b1;
        repeat (5) step();
        chk("idle_outs", outs(), '0);
        // Asynchronous abort while the FF chain is shifting
        start = 1'b1; dir = 1'b0;
        step(); start = 1'b0;
        for (int i = 0; i < 5 && !s_ff_se; i++) step();
        chk("midop_in_ff_shift", DW'(s_ff_se), 1);
        #2 resetn = 1'b0;
        #1 chk("async_reset_outs", outs(), '0);
        step(); resetn = 1'b1; step();
        // Dump: A0..A2 / B0..B4 must land at 0..7, FF chain must be intact afterwards
        for (int i = 0; i < 3; i++) ffc[i] = a_w[i];
        for (int i = 0; i < 5; i++) mem[i] = b_w[i];
        for (int i = 0; i < 8; i++) bm[i] = '0;
        drive_model();
        run_op(1'b0, 0);
        chk("dump_done_at", DW'(done_at), 13);
        chk("dump_pause_cyc", DW'(npause), 12);
        chk("dump_busy_cyc", DW'(nbusy), 12);
        chk("dump_ff_se_cyc", DW'(nff), 3);
        chk("dump_ram_se_cyc", DW'(nram), 7);
        chk("dump_se_overlap", DW'(nboth), 0);
        for (int i = 0; i < 3; i++) chk($sformatf("dump_buf_ff%0d", i), bm[i], a_w[i]);
        for (int i = 0; i < 5; i++) chk($sformatf("dump_buf_ram%0d", i), bm[3+i], b_w[i]);
        for (int i = 0; i < 3; i++) chk($sformatf("recirc_ff%0d", i), ffc[i], a_w[i]);
        // Round trip: scribble the chains, load back from the buffer
        for (int i = 0; i < 3; i++) ffc[i] = ~a_w[i];
        for (int i = 0; i < 5; i++) mem[i] = 64'h5C5C_5C5C_0000_0000 + DW'(i);
        drive_model();
        run_op(1'b1, 0);
        chk("load_done_at", DW'(done_at), 12);
        chk("load_pause_cyc", DW'(npause), 11);
        chk("load_se_overlap", DW'(nboth), 0);
        for (int i = 0; i < 3; i++) chk($sformatf("rt_ff%0d", i), ffc[i], a_w[i]);
        for (int i = 0; i < 5; i++) chk($sformatf("rt_mem%0d", i), mem[i], b_w[i]);
        // Load from buffer 0x10..0x17: scan-in data order
        for (int i = 0; i < 8; i++) bm[i] = 64'h10 + DW'(i);
        run_op(1'b1, 0);
        for (int i = 0; i < 3; i++) chk($sformatf("load_ff_di%0d", i), ffdi[i], 64'h10 + DW'(i));
        for (int i = 0; i < 5; i++) chk($sformatf("load_ram_di%0d", i), ramdi[i], 64'h13 + DW'(i));
        chk("load_ram_se_cyc", DW'(nram), 6);
        chk("load_ram_sd_cyc", DW'(nsd), 6);
        chk("load_ff_se_cyc", DW'(nff), 3);
        // start pulsed while busy must be ignored
        run_op(1'b0, 5);
        chk("poke_done_at", DW'(done_at), 13);
        step();
        chk("poke_no_restart", DW'({s_busy, s_pause}), 0);
        // start held: dump then (dir re-sampled in DONE) load, SETTLE directly after DONE
        start = 1'b1; dir = 1'b0;
        watch(1'b0, 0);
        chk("b2b_first_done_at", DW'(done_at), 13);
        dir = 1'b1;
        watch(1'b1, 0);
        chk("b2b_settle_after_done", DW'(first_settle), 1);
        chk("b2b_second_is_load", DW'(done_at), 12);
        chk("b2b_second_sd_cyc", DW'(nsd), 6);
        step();
        chk("final_idle", outs() & ~DW'(7), '0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
